seg_range_scanner: RTL and testbench

Sequencer for the piecewise sigmoid/tanh approximation datapath. Accepts one unsigned magnitude per handshake, walks a programmable breakpoint table one segment per clock, and tests each half-open range [bp[k], bp[k+1]) with a single shared `biggerOrEqualAndSmaller` comparator instance. Returns the matching segment index, which downstream logic uses to select slope/offset coefficients.

---
 rtl/sigmoid_tanh_pkg.sv | 36 +++
 rtl/biggerOrEqualAndSmaller.sv | 16 +
 rtl/seg_range_scanner.sv | 138 +++++++++++++
 tb/tb_seg_range_scanner.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_tanh_pkg.sv
// Shared types and constants for the sigmoid/tanh segment scanner.
// Breakpoint defaults split the magnitude axis into eight ranges, finer near zero.
package sigmoid_tanh_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BP_DEF_0 = 0;
    localparam int BP_DEF_1 = 256;
    localparam int BP_DEF_2 = 512;
    localparam int BP_DEF_3 = 1024;
    localparam int BP_DEF_4 = 1536;
    localparam int BP_DEF_5 = 2048;
    localparam int BP_DEF_6 = 3072;
    localparam int BP_DEF_7 = 4096;
    localparam int BP_DEF_8 = 8192;

    function automatic int bp_default(input int k);
        case (k)
            0:       return BP_DEF_0;
            1:       return BP_DEF_1;
            2:       return BP_DEF_2;
            3:       return BP_DEF_3;
            4:       return BP_DEF_4;
            5:       return BP_DEF_5;
            6:       return BP_DEF_6;
            7:       return BP_DEF_7;
            8:       return BP_DEF_8;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/biggerOrEqualAndSmaller.sv
// Half-open range test a <= xAbs < b, combinational (zero latency, no backpressure).
// Output is forced low while disabled or while reset is asserted.
module biggerOrEqualAndSmaller #(
    parameter int xDW = 16
) (
    input  logic           rst_n,
    input  logic           en,
    input  logic [xDW-1:0] a,
    input  logic [xDW-1:0] b,
    input  logic [xDW-1:0] xAbs,
    output logic           hit
);

    assign hit = rst_n && en && (xAbs >= a) && (xAbs < b);

endmodule

// File: rtl/seg_range_scanner.sv
// Finds the breakpoint segment holding a magnitude, one segment tested per clock.
// Latency idx+1 clocks on a hit, NSEG on a miss; one request in flight, result held until out_ready.
module seg_range_scanner
    import sigmoid_tanh_pkg::*;
#(
    parameter int xDW  = 16,
    parameter int NSEG = 8,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [IDXW:0]   cfg_addr,
    input  logic [xDW-1:0]  cfg_data,
    output logic            cfg_drop,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [xDW-1:0]  x_abs,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] seg_idx,
    output logic            seg_hit,
    output logic            busy
);

    localparam int AW = IDXW + 1;

    state_t          state;
    state_t          state_nxt;
    logic [IDXW-1:0] cnt;
    logic [xDW-1:0]  x_q;
    logic [xDW-1:0]  bp [NSEG+1];

    logic [IDXW:0]   cnt_ext;
    logic [IDXW:0]   cnt_p1;
    logic [xDW-1:0]  bp_lo;
    logic [xDW-1:0]  bp_hi;
    logic            scan_en;
    logic            cmp_hit;
    logic            last_seg;
    logic            accept;
    logic            cfg_ok;
    logic            cfg_bad;

    assign scan_en  = (state == SCAN);
    assign accept   = in_valid && (state == IDLE);
    assign cnt_ext  = {1'b0, cnt};
    assign cnt_p1   = cnt_ext + AW'(1);
    assign bp_lo    = bp[cnt_ext];
    assign bp_hi    = bp[cnt_p1];
    assign last_seg = (cnt == IDXW'(NSEG - 1));

    assign cfg_ok   = cfg_we && (state == IDLE) && (cfg_addr <= AW'(NSEG));
    assign cfg_bad  = cfg_we && !cfg_ok;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    biggerOrEqualAndSmaller #(
        .xDW (xDW)
    ) u_cmp (
        .rst_n (rst_n),
        .en    (scan_en),
        .a     (bp_lo),
        .b     (bp_hi),
        .xAbs  (x_q),
        .hit   (cmp_hit)
    );

    // Breakpoint table; writes only land while idle so a scan sees a frozen table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NSEG; k++) begin
                bp[k] <= xDW'(bp_default(k));
            end
        end else if (cfg_ok) begin
            for (int k = 0; k <= NSEG; k++) begin
                if (cfg_addr == AW'(k)) begin
                    bp[k] <= cfg_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_drop <= 1'b0;
        end else begin
            cfg_drop <= cfg_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)               state_nxt = SCAN;
            SCAN:    if (cmp_hit || last_seg)    state_nxt = DONE;
            DONE:    if (out_ready)              state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            x_q     <= '0;
            seg_idx <= '0;
            seg_hit <= 1'b0;
        end else begin
            if (accept) begin
                x_q <= x_abs;
                cnt <= '0;
            end
            if (scan_en) begin
                if (cmp_hit) begin
                    seg_idx <= cnt;
                    seg_hit <= 1'b1;
                end else if (last_seg) begin
                    // No range matched: saturate to whichever end of the table x lies past.
                    seg_hit <= 1'b0;
                    seg_idx <= (x_q >= bp[NSEG]) ? IDXW'(NSEG - 1) : '0;
                end else begin
                    cnt <= cnt + IDXW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_range_scanner.sv
// Self-checking bench for seg_range_scanner against a table-walk reference model.
module tb_seg_range_scanner;

    localparam int XW = 16;
    localparam int NS = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW:0]   cfg_addr = '0;
    logic [XW-1:0] cfg_data = '0;
    logic          cfg_drop;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [XW-1:0] x_abs = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] seg_idx;
    logic          seg_hit;
    logic          busy;

    int tests = 0;
    int fails = 0;
    int mbp [NS+1];

    seg_range_scanner #(.xDW(XW), .NSEG(NS), .IDXW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_drop  (cfg_drop),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_abs     (x_abs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .seg_idx   (seg_idx),
        .seg_hit   (seg_hit),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic model_defaults();
        mbp = '{0, 256, 512, 1024, 1536, 2048, 3072, 4096, 8192};
    endtask

    // First range [bp[k], bp[k+1]) containing x wins; otherwise saturate.
    function automatic void model(input int x, output int idx, output int hit, output int lat);
        hit = 0;
        idx = 0;
        lat = NS;
        for (int k = 0; k < NS; k++) begin
            if (hit == 0 && x >= mbp[k] && x < mbp[k+1]) begin
                hit = 1;
                idx = k;
                lat = k + 1;
            end
        end
        if (hit == 0) idx = (x >= mbp[NS]) ? NS - 1 : 0;
    endfunction

    task automatic cfg_write(input int addr, input int data, output logic drop);
        cfg_we   = 1'b1;
        cfg_addr = addr[IW:0];
        cfg_data = data[XW-1:0];
        @(posedge clk); @(negedge clk);
        cfg_we = 1'b0;
        drop = cfg_drop;
    endtask

    task automatic run_req(input int x, input int hold, output int lat, output int idx,
                           output int hit, output logic ready_after);
        in_valid = 1'b1;
        x_abs    = x[XW-1:0];
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < NS + 4) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        idx = int'(seg_idx);
        hit = int'(seg_hit);
        repeat (hold) begin @(posedge clk); @(negedge clk); end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        ready_after = in_ready && !out_valid;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs rdy=%b vld=%b busy=%b exp 1 0 0", in_ready, out_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (seg_idx !== 3'd0 || seg_hit !== 1'b0 || cfg_drop !== 1'b0) begin
            fails++;
            $display("FAIL reset_out idx=%0d hit=%b drop=%b exp 0 0 0", seg_idx, seg_hit, cfg_drop);
        end
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_rel rdy=%b vld=%b busy=%b exp 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    typedef struct { int x; int idx; int hit; int lat; } vec_t;

    task automatic test_defaults();
        vec_t dv [7];
        int lat, idx, hit;
        logic ra;
        dv = '{'{300, 1, 1, 2}, '{0, 0, 1, 1}, '{8191, 7, 1, 8}, '{9000, 7, 0, 8},
               '{8192, 7, 0, 8}, '{255, 0, 1, 1}, '{1536, 4, 1, 5}};
        foreach (dv[i]) begin
            run_req(dv[i].x, 0, lat, idx, hit, ra);
            tests++;
            if (idx !== dv[i].idx || hit !== dv[i].hit || lat !== dv[i].lat || ra !== 1'b1) begin
                fails++;
                $display("FAIL default x=%0d got idx=%0d hit=%0d lat=%0d rdy=%b exp %0d %0d %0d 1",
                         dv[i].x, idx, hit, lat, ra, dv[i].idx, dv[i].hit, dv[i].lat);
            end
        end
    endtask

    task automatic test_program();
        int lat, idx, hit;
        logic ra, drop;
        cfg_write(1, 100, drop);
        mbp[1] = 100;
        tests++;
        if (drop !== 1'b0) begin
            fails++;
            $display("FAIL prog_nodrop drop=%b exp 0", drop);
        end
        run_req(150, 0, lat, idx, hit, ra);
        tests++;
        if (idx !== 1 || hit !== 1 || lat !== 2) begin
            fails++;
            $display("FAIL prog_x150 got idx=%0d hit=%0d lat=%0d exp 1 1 2", idx, hit, lat);
        end
        // Write while scanning: must be dropped with a one-cycle pulse.
        in_valid = 1'b1; x_abs = 16'd150;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 16'd999;
        @(posedge clk); @(negedge clk);
        cfg_we = 1'b0;
        tests++;
        if (cfg_drop !== 1'b1) begin
            fails++;
            $display("FAIL scan_drop drop=%b exp 1", cfg_drop);
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if (cfg_drop !== 1'b0 || out_valid !== 1'b1 || seg_idx !== 3'd1) begin
            fails++;
            $display("FAIL scan_drop_after drop=%b vld=%b idx=%0d exp 0 1 1", cfg_drop, out_valid, seg_idx);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        run_req(150, 0, lat, idx, hit, ra);
        tests++;
        if (idx !== 1 || hit !== 1 || lat !== 2) begin
            fails++;
            $display("FAIL table_kept got idx=%0d hit=%0d lat=%0d exp 1 1 2", idx, hit, lat);
        end
        cfg_write(9, 5, drop);
        tests++;
        if (drop !== 1'b1) begin
            fails++;
            $display("FAIL addr_drop drop=%b exp 1", drop);
        end
        // Write and accept in the same idle cycle: new bp[2] applies to this request.
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 16'd120;
        run_req(130, 0, lat, idx, hit, ra);
        mbp[2] = 120;
        tests++;
        if (idx !== 2 || hit !== 1 || lat !== 3) begin
            fails++;
            $display("FAIL cfg_accept got idx=%0d hit=%0d lat=%0d exp 2 1 3", idx, hit, lat);
        end
    endtask

    task automatic test_backpressure();
        int eidx, ehit, elat, n;
        model(1000, eidx, ehit, elat);
        in_valid = 1'b1; x_abs = 16'd1000;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < NS + 4) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (out_valid !== 1'b1 || int'(seg_idx) !== eidx || int'(seg_hit) !== ehit
                || in_ready !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL hold c=%0d vld=%b idx=%0d hit=%b rdy=%b busy=%b exp 1 %0d %0d 0 1",
                         c, out_valid, seg_idx, seg_hit, in_ready, busy, eidx, ehit);
            end
            @(posedge clk); @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL release vld=%b rdy=%b busy=%b exp 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat, idx, hit;
        logic ra, seen;
        in_valid = 1'b1; x_abs = 16'd5000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || seg_idx !== 3'd0) begin
            fails++;
            $display("FAIL midrst rdy=%b vld=%b busy=%b idx=%0d exp 1 0 0 0", in_ready, out_valid, busy, seg_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_defaults();
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL midrst_noout out_valid seen=%b exp 0", seen);
        end
        run_req(150, 0, lat, idx, hit, ra);
        tests++;
        if (idx !== 0 || hit !== 1 || lat !== 1) begin
            fails++;
            $display("FAIL midrst_defaults got idx=%0d hit=%0d lat=%0d exp 0 1 1", idx, hit, lat);
        end
    endtask

    task automatic test_random();
        int lat, idx, hit, eidx, ehit, elat, v, x;
        logic ra, drop;
        for (int r = 0; r < 6; r++) begin
            v = $urandom_range(0, 200);
            for (int k = 0; k <= NS; k++) begin
                if (r % 3 == 2) v = $urandom_range(0, 9000);
                cfg_write(k, v, drop);
                mbp[k] = v;
                tests++;
                if (drop !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_cfg k=%0d drop=%b exp 0", k, drop);
                end
                v = v + $urandom_range(1, 1500);
            end
            cfg_write($urandom_range(NS + 1, 15), $urandom_range(0, 65535), drop);
            tests++;
            if (drop !== 1'b1) begin
                fails++;
                $display("FAIL rand_baddr drop=%b exp 1", drop);
            end
            for (int q = 0; q < 6; q++) begin
                x = $urandom_range(0, 13000);
                model(x, eidx, ehit, elat);
                run_req(x, $urandom_range(0, 2), lat, idx, hit, ra);
                tests++;
                if (idx !== eidx || hit !== ehit || lat !== elat || ra !== 1'b1) begin
                    fails++;
                    $display("FAIL rand x=%0d got idx=%0d hit=%0d lat=%0d rdy=%b exp %0d %0d %0d 1",
                             x, idx, hit, lat, ra, eidx, ehit, elat);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_defaults();
        test_reset();
        test_defaults();
        test_program();
        test_backpressure();
        test_reset_mid_scan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
